pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard unit: operand forwarding, load-use stall, branch flush and data-memory wait sequencing.
// Optional performance counters are built only when PIPELINE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MEM_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             regWrite_M,
    input  logic             regWrite_W,
    input  logic [1:0]       resultSrc_E,
    input  logic             PCsrc_E,
    input  logic             memAccess_M,
    output logic [1:0]       forwardA_E,
    output logic [1:0]       forwardB_E,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [WIDTH-1:0] stallCnt,
    output logic [WIDTH-1:0] flushCnt
);

    // state | meaning
    // IDLE  | no access in flight; a new access stalls this cycle
    // WAIT  | access in flight, cnt = stall cycles still to go
    // DONE  | access completes, pipeline released for one cycle
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       mem_stall;
    logic       lw_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memAccess_M && MEM_WAIT >= 2) begin
                        state <= S_WAIT;
                        cnt   <= WAIT_LOAD;
                    end else if (memAccess_M && MEM_WAIT == 1) begin
                        state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) state <= S_DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_stall = rst && ((state == S_IDLE && memAccess_M && MEM_WAIT != 0) ||
                               state == S_WAIT);

    assign lw_stall = resultSrc_E == 2'b01 && Rd_E != 5'd0 &&
                      (Rd_E == Rs1_D || Rd_E == Rs2_D);

    always_comb begin
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
        if (rst) begin
            if (regWrite_M && Rd_M != 5'd0 && Rd_M == Rs1_E)      forwardA_E = 2'b10;
            else if (regWrite_W && Rd_W != 5'd0 && Rd_W == Rs1_E) forwardA_E = 2'b01;
            if (regWrite_M && Rd_M != 5'd0 && Rd_M == Rs2_E)      forwardB_E = 2'b10;
            else if (regWrite_W && Rd_W != 5'd0 && Rd_W == Rs2_E) forwardB_E = 2'b01;
        end
    end

    // Memory wait dominates, then a taken branch, then the load-use bubble.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (mem_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
        end else if (rst && PCsrc_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (rst && lw_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stall_F && stallCnt != '1) stallCnt <= stallCnt + CNT_ONE;
            if (flush_D && flushCnt != '1) flushCnt <= flushCnt + CNT_ONE;
        end
    end
`else
    assign stallCnt = '0;
    assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl: two instances (MEM_WAIT=2 and MEM_WAIT=0) checked against a
// remaining-cycles reference model.
module tb_pipeline_ctrl;

    localparam int W = 4;
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       regWrite_M, regWrite_W, PCsrc_E, memAccess_M;
    logic [1:0] resultSrc_E;

    logic [1:0]   fwd_a [2];
    logic [1:0]   fwd_b [2];
    logic         st_f [2], st_d [2], st_e [2], st_m [2];
    logic         fl_d [2], fl_e [2], fl_w [2];
    logic [W-1:0] s_cnt [2], f_cnt [2];

    pipeline_ctrl #(.WIDTH(W), .MEM_WAIT(2)) dut (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .resultSrc_E(resultSrc_E), .PCsrc_E(PCsrc_E), .memAccess_M(memAccess_M),
        .forwardA_E(fwd_a[0]), .forwardB_E(fwd_b[0]), .stall_F(st_f[0]), .stall_D(st_d[0]),
        .stall_E(st_e[0]), .stall_M(st_m[0]), .flush_D(fl_d[0]), .flush_E(fl_e[0]),
        .flush_W(fl_w[0]), .stallCnt(s_cnt[0]), .flushCnt(f_cnt[0]));

    pipeline_ctrl #(.WIDTH(W), .MEM_WAIT(0)) dut_nowait (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .resultSrc_E(resultSrc_E), .PCsrc_E(PCsrc_E), .memAccess_M(memAccess_M),
        .forwardA_E(fwd_a[1]), .forwardB_E(fwd_b[1]), .stall_F(st_f[1]), .stall_D(st_d[1]),
        .stall_E(st_e[1]), .stall_M(st_m[1]), .flush_D(fl_d[1]), .flush_E(fl_e[1]),
        .flush_W(fl_w[1]), .stallCnt(s_cnt[1]), .flushCnt(f_cnt[1]));

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: an access costs mw[i] stall cycles followed by one release cycle.
    int mw [2] = '{2, 0};
    int remaining [2];
    bit done [2];
    int m_scnt [2];
    int m_fcnt [2];

    function automatic bit m_mem_stall(input int i);
        if (!rst || done[i]) return 1'b0;
        if (remaining[i] > 0) return 1'b1;
        return memAccess_M && mw[i] > 0;
    endfunction

    // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
    function automatic logic [6:0] m_ctrl(input int i);
        bit lw;
        lw = resultSrc_E == 2'b01 && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D);
        if (!rst)           return 7'b0000000;
        if (m_mem_stall(i)) return 7'b1111001;
        if (PCsrc_E)        return 7'b0000110;
        if (lw)             return 7'b1100010;
        return 7'b0000000;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (!rst) return 2'b00;
        if (regWrite_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
        if (regWrite_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        logic [6:0] e [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            e[i] = m_ctrl(i);
            check($sformatf("ctrl%0d", i),
                  {st_f[i], st_d[i], st_e[i], st_m[i], fl_d[i], fl_e[i], fl_w[i]}, e[i]);
            check($sformatf("fwdA%0d", i), fwd_a[i], m_fwd(Rs1_E));
            check($sformatf("fwdB%0d", i), fwd_b[i], m_fwd(Rs2_E));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                remaining[i] = 0;
                done[i] = 1'b0;
                m_scnt[i] = 0;
                m_fcnt[i] = 0;
            end else begin
                if (PERF && e[i][6] && m_scnt[i] < 2**W - 1) m_scnt[i]++;
                if (PERF && e[i][2] && m_fcnt[i] < 2**W - 1) m_fcnt[i]++;
                if (done[i]) begin
                    done[i] = 1'b0;
                end else if (remaining[i] > 0) begin
                    remaining[i]--;
                    if (remaining[i] == 0) done[i] = 1'b1;
                end else if (memAccess_M && mw[i] > 0) begin
                    remaining[i] = mw[i] - 1;
                    if (remaining[i] == 0) done[i] = 1'b1;
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("stallCnt%0d", i), 32'(s_cnt[i]), 32'(m_scnt[i]));
            check($sformatf("flushCnt%0d", i), 32'(f_cnt[i]), 32'(m_fcnt[i]));
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
        {regWrite_M, regWrite_W, PCsrc_E, memAccess_M} = '0;
        resultSrc_E = 2'b00;
    endtask

    int n_stall [2];

    initial begin
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            remaining[i] = 0; done[i] = 1'b0; m_scnt[i] = 0; m_fcnt[i] = 0;
        end
        @(negedge clk);
        Rd_M = 5'd5; regWrite_M = 1'b1; Rs1_E = 5'd5; memAccess_M = 1'b1; PCsrc_E = 1'b1;
        #1;
        check("rst_fwdA", fwd_a[0], 2'b00);
        check("rst_stallF", st_f[0], 1'b0);
        step();
        step();
        rst = 1'b1;
        clear_inputs();
        step();

        // Forwarding priority
        Rd_M = 5'd5; regWrite_M = 1'b1; Rd_W = 5'd5; regWrite_W = 1'b1; Rs1_E = 5'd5;
        #1 check("fwdA_mem", fwd_a[0], 2'b10);
        step();
        Rd_M = 5'd0;
        #1 check("fwdA_wb", fwd_a[0], 2'b01);
        step();

        // Load-use stall, x0 exemption, branch override
        clear_inputs();
        resultSrc_E = 2'b01; Rd_E = 5'd7; Rs2_D = 5'd7;
        #1 check("lw_stallF", {st_f[0], st_d[0], fl_e[0]}, 3'b111);
        step();
        Rd_E = 5'd0;
        #1 check("lw_x0", {st_f[0], st_d[0], fl_e[0]}, 3'b000);
        step();
        Rd_E = 5'd7; PCsrc_E = 1'b1;
        #1 check("br_over_lw", {fl_d[0], fl_e[0], st_f[0]}, 3'b110);
        step();

        // Long load-use run drives the stall counter into saturation when enabled
        PCsrc_E = 1'b0;
        repeat (20) step();

        // Single memory access
        clear_inputs();
        n_stall = '{0, 0};
        memAccess_M = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            for (int i = 0; i < 2; i++) if (st_m[i]) n_stall[i]++;
            step();
            memAccess_M = 1'b0;
        end
        check("mem_wait2_cycles", n_stall[0], 2);
        check("mem_wait0_cycles", n_stall[1], 0);

        // Reset during WAIT aborts the access
        memAccess_M = 1'b1;
        step();
        memAccess_M = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1 check("abort_stallM", st_m[0], 1'b0);
        step();
        step();

        // Randomized traffic
        for (int c = 0; c < 500; c++) begin
            rst         = $urandom_range(0, 24) != 0;
            Rs1_D       = 5'($urandom_range(0, 3));
            Rs2_D       = 5'($urandom_range(0, 3));
            Rs1_E       = 5'($urandom_range(0, 3));
            Rs2_E       = 5'($urandom_range(0, 3));
            Rd_E        = 5'($urandom_range(0, 3));
            Rd_M        = 5'($urandom_range(0, 3));
            Rd_W        = 5'($urandom_range(0, 3));
            regWrite_M  = 1'($urandom_range(0, 1));
            regWrite_W  = 1'($urandom_range(0, 1));
            resultSrc_E = 2'($urandom_range(0, 3));
            PCsrc_E     = $urandom_range(0, 4) == 0;
            memAccess_M = $urandom_range(0, 3) == 0;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
